// File: rtl/mem_responder.sv
// Backing-memory responder for the data cache miss interface.
// Serves read/write misses after a programmable latency and holds each response until acked.
module mem_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHit,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    input  logic        MemReadDone,
    input  logic        MemWriteReady,
    output logic        MemReadReady,
    output logic        MemWriteDone,
    output logic [31:0] MemReadData,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
        $error("mem_responder: READ_LATENCY must be in 1..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
        $error("mem_responder: WRITE_LATENCY must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP,
        RELEASE
    } state_t;

    state_t                  state, next_state;
    logic [3:0]              cnt, cnt_next;
    logic [ADDR_WIDTH-1:0]   idx, idx_next;
    logic                    rd_ready_next, wr_done_next;
    logic                    load_rd, load_wr, mem_we;
    logic [31:0]             mem [DEPTH];

    logic miss_rd, miss_wr, no_req;
    logic unused_addr;

    assign miss_rd = MemRead & ~MemHit;
    assign miss_wr = MemWrite & ~MemHit & ~MemRead;
    assign no_req  = ~MemRead & ~MemWrite;
    assign busy    = (state != IDLE);

    // Byte offset and bits above the word index are dropped, so high addresses alias.
    assign unused_addr = ^{memAddr[31:ADDR_WIDTH+2], memAddr[1:0]};

    always_comb begin
        next_state    = state;
        cnt_next      = cnt;
        idx_next      = idx;
        rd_ready_next = MemReadReady;
        wr_done_next  = MemWriteDone;
        load_rd       = 1'b0;
        load_wr       = 1'b0;
        mem_we        = 1'b0;
        case (state)
            IDLE: begin
                if (miss_rd) begin
                    idx_next   = memAddr[ADDR_WIDTH+1:2];
                    cnt_next   = RD_LOAD;
                    next_state = RD_WAIT;
                end else if (miss_wr) begin
                    idx_next   = memAddr[ADDR_WIDTH+1:2];
                    cnt_next   = WR_LOAD;
                    next_state = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (no_req) begin
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    rd_ready_next = 1'b1;
                    load_rd       = 1'b1;
                    next_state    = RD_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            // A request that disappears without an ack is treated as an ack.
            RD_RESP: begin
                if (MemReadDone || no_req) begin
                    rd_ready_next = 1'b0;
                    next_state    = RELEASE;
                end
            end
            WR_WAIT: begin
                if (no_req) begin
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    mem_we       = 1'b1;
                    load_wr      = 1'b1;
                    wr_done_next = 1'b1;
                    next_state   = WR_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            WR_RESP: begin
                if (MemWriteReady || no_req) begin
                    wr_done_next = 1'b0;
                    next_state   = RELEASE;
                end
            end
            RELEASE: begin
                rd_ready_next = 1'b0;
                wr_done_next  = 1'b0;
                next_state    = IDLE;
            end
            default: begin
                rd_ready_next = 1'b0;
                wr_done_next  = 1'b0;
                next_state    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx          <= '0;
            MemReadReady <= 1'b0;
            MemWriteDone <= 1'b0;
            MemReadData  <= 32'd0;
        end else begin
            state        <= next_state;
            cnt          <= cnt_next;
            idx          <= idx_next;
            MemReadReady <= rd_ready_next;
            MemWriteDone <= wr_done_next;
            if (load_rd) begin
                MemReadData <= mem[idx];
            end else if (load_wr) begin
                MemReadData <= memWriteData;
            end
        end
    end

    // RAM is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx] <= memWriteData;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes expected responses into a scoreboard
// and a negedge monitor pops and checks kind, data and arrival cycle of each response.
module tb_mem_responder;

    localparam int RL = 4;
    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, MemHit;
    logic [31:0] memAddr, memWriteData;
    logic        MemReadDone, MemWriteReady;
    logic        MemReadReady, MemWriteDone;
    logic [31:0] MemReadData;
    logic        busy;

    typedef struct {
        bit          isWrite;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;
    logic prevStrobe = 1'b0;

    mem_responder #(
        .ADDR_WIDTH(10),
        .READ_LATENCY(RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .MemHit(MemHit),
        .memAddr(memAddr),
        .memWriteData(memWriteData),
        .MemReadDone(MemReadDone),
        .MemWriteReady(MemWriteReady),
        .MemReadReady(MemReadReady),
        .MemWriteDone(MemWriteDone),
        .MemReadData(MemReadData),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Response monitor: each new strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prevStrobe <= 1'b0;
        end else begin
            checkOutput("strobes exclusive", {31'd0, MemReadReady & MemWriteDone}, 32'd0);
            if ((MemReadReady || MemWriteDone) && !prevStrobe) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected response", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp kind write", {31'd0, MemWriteDone}, {31'd0, e.isWrite});
                    checkOutput("resp kind read", {31'd0, MemReadReady}, {31'd0, !e.isWrite});
                    checkOutput("resp data", MemReadData, e.data);
                    checkOutput("resp cycle", cyc, e.due);
                end
            end
            prevStrobe <= MemReadReady | MemWriteDone;
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expWrite,
                                 input logic [31:0] expData);
        exp_t e;
        @(posedge clk);
        #1;
        MemRead      = rd;
        MemWrite     = wr;
        MemHit       = 1'b0;
        memAddr      = addr;
        memWriteData = wdata;
        e.isWrite = expWrite;
        e.data    = expData;
        e.due     = cyc + 1 + (expWrite ? WL : RL);
        sb.push_back(e);
    endtask

    task automatic waitStrobe();
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MemReadReady || MemWriteDone) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("response timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic ackAndRelease(input bit isWrite);
        @(posedge clk);
        #1;
        if (isWrite) MemWriteReady = 1'b1;
        else         MemReadDone   = 1'b1;
        @(posedge clk);
        #1;
        MemReadDone   = 1'b0;
        MemWriteReady = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        checkOutput("strobe cleared", {30'd0, MemReadReady, MemWriteDone}, 32'd0);
        checkOutput("release busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("idle busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic doMiss(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit expWrite,
                          input logic [31:0] expData);
        applyStimulus(rd, wr, addr, wdata, expWrite, expData);
        waitStrobe();
        ackAndRelease(expWrite);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        reset         = 1'b1;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemHit        = 1'b0;
        memAddr       = 32'd0;
        memWriteData  = 32'd0;
        MemReadDone   = 1'b0;
        MemWriteReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset MemReadReady", {31'd0, MemReadReady}, 32'd0);
        checkOutput("reset MemWriteDone", {31'd0, MemWriteDone}, 32'd0);
        checkOutput("reset MemReadData", MemReadData, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        $display("[TB] preload word 5 and read it back");
        doMiss(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        doMiss(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("[TB] write miss to 0x20 and readback");
        doMiss(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h12345678);
        doMiss(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);

        $display("[TB] read and write together: read wins");
        doMiss(1'b1, 1'b1, 32'h14, 32'h00000BAD, 1'b0, 32'hDEADBEEF);
        doMiss(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("[TB] cache hit is ignored");
        @(posedge clk);
        #1;
        MemRead = 1'b1;
        MemHit  = 1'b1;
        memAddr = 32'h14;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hit busy", {31'd0, busy}, 32'd0);
            checkOutput("hit strobes", {30'd0, MemReadReady, MemWriteDone}, 32'd0);
        end
        MemRead = 1'b0;
        MemHit  = 1'b0;

        $display("[TB] reset during write wait");
        @(posedge clk);
        #1;
        MemWrite     = 1'b1;
        memAddr      = 32'h20;
        memWriteData = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        checkOutput("wr wait busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort strobes", {30'd0, MemReadReady, MemWriteDone}, 32'd0);
        checkOutput("abort data", MemReadData, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        reset    = 1'b0;
        MemWrite = 1'b0;
        doMiss(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);

        $display("[TB] aliased address and back-to-back reads");
        applyStimulus(1'b1, 1'b0, 32'h1014, 32'h0, 1'b0, 32'hDEADBEEF);
        waitStrobe();
        @(posedge clk);
        #1;
        MemReadDone = 1'b1;
        e.isWrite = 1'b0;
        e.data    = 32'h12345678;
        e.due     = cyc + 3 + RL;
        sb.push_back(e);
        @(posedge clk);
        #1;
        MemReadDone = 1'b0;
        memAddr     = 32'h20;
        checkOutput("b2b ready dropped", {31'd0, MemReadReady}, 32'd0);
        checkOutput("b2b release busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b accept busy", {31'd0, busy}, 32'd1);
        memAddr = 32'h14;
        waitStrobe();
        ackAndRelease(1'b0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
